// File: rtl/dtu_cq_gen_pkg.sv
// dtu_cq_gen_pkg: lynxTypes additions for the DTU bypass completion-queue generator.
// Widths of pid/dest and the default tracking depth live here.
package dtu_cq_gen_pkg;
    localparam int PID_BITS     = 6;
    localparam int DEST_BITS    = 4;
    localparam int DTU_CQ_DEPTH = 16;

    typedef enum logic {CQ_RD = 1'b0, CQ_WR = 1'b1} cq_opcode_t;

    typedef struct packed {
        cq_opcode_t           opcode;
        logic [PID_BITS-1:0]  pid;
        logic [DEST_BITS-1:0] dest;
    } dtu_cq_t;
endpackage

// File: rtl/dtu_cq_fifo.sv
// dtu_cq_fifo: synchronous FIFO with registered full/empty flags and an occupancy count.
// Head data is presented combinationally; push while full and pop while empty are ignored.
module dtu_cq_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count, w_count_nx;
    logic          r_full, r_empty, w_push, w_pop;

    assign w_push     = i_push & ~r_full;
    assign w_pop      = i_pop & ~r_empty;
    assign w_count_nx = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= w_count_nx;
            r_full  <= w_count_nx == (AW+1)'(DEPTH);
            r_empty <= w_count_nx == '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;
endmodule

// File: rtl/dtu_cq_gen.sv
// dtu_cq_gen: tracks bypass rd/wr descriptors in issue order and emits one CQ entry per retired
// descriptor with last=1. Optional statistics ports are enabled by defining DTU_CQ_STATS_EN.
module dtu_cq_gen
    import dtu_cq_gen_pkg::*;
#(
    parameter int DEPTH = DTU_CQ_DEPTH
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      rd_req_valid,
    output logic                      rd_req_ready,
    input  logic [PID_BITS-1:0]       rd_req_pid,
    input  logic [DEST_BITS-1:0]      rd_req_dest,
    input  logic                      rd_req_last,
    input  logic                      wr_req_valid,
    output logic                      wr_req_ready,
    input  logic [PID_BITS-1:0]       wr_req_pid,
    input  logic [DEST_BITS-1:0]      wr_req_dest,
    input  logic                      wr_req_last,
    input  logic                      rd_done,
    input  logic                      wr_done,
    output logic                      cq_valid,
    input  logic                      cq_ready,
    output logic                      cq_opcode,
    output logic [PID_BITS-1:0]       cq_pid,
    output logic [DEST_BITS-1:0]      cq_dest,
    output logic                      err_underflow
`ifdef DTU_CQ_STATS_EN
    ,
    output logic [31:0]               stat_rd_cmpl,
    output logic [31:0]               stat_wr_cmpl,
    output logic [$clog2(DEPTH):0]    stat_rd_outst,
    output logic [$clog2(DEPTH):0]    stat_wr_outst
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = 1 + PID_BITS + DEST_BITS;

    // Index 0 is the read direction, index 1 the write direction throughout.
    logic [1:0]          w_valid, w_ready, w_push, w_full, w_empty, w_last;
    logic [1:0]          w_cand, w_want, w_win, w_pop, w_under, w_inc;
    logic [1:0][DW-1:0]  w_din, w_head;
    logic [1:0][CW-1:0]  w_occ, r_done_cnt;
    logic [1:0]          r_done_q;
    logic [DW-1:0]       w_sel;
    logic                r_rr, r_err, r_cq_valid, w_slot_free, w_contend;
    dtu_cq_t             r_cq;

    assign w_valid = {wr_req_valid, rd_req_valid};
    assign w_din[0] = {rd_req_last, rd_req_pid, rd_req_dest};
    assign w_din[1] = {wr_req_last, wr_req_pid, wr_req_dest};
    assign rd_req_ready = w_ready[0];
    assign wr_req_ready = w_ready[1];

    genvar d;
    for (d = 0; d < 2; d++) begin : g_dir
        assign w_ready[d] = ~w_full[d] & ~areset;
        assign w_push[d]  = w_valid[d] & w_ready[d];
        assign w_last[d]  = w_head[d][DW-1];
        assign w_cand[d]  = (r_done_cnt[d] != '0) & ~w_empty[d];
        assign w_want[d]  = w_cand[d] & w_last[d];
        assign w_pop[d]   = w_cand[d] & (~w_last[d] | w_win[d]);
        assign w_under[d] = r_done_q[d] & (r_done_cnt[d] == w_occ[d]);
        assign w_inc[d]   = r_done_q[d] & ~w_under[d];

        dtu_cq_fifo #(.DEPTH(DEPTH), .W(DW)) u_fifo (
            .aclk    (aclk),
            .areset  (areset),
            .i_push  (w_push[d]),
            .i_data  (w_din[d]),
            .i_pop   (w_pop[d]),
            .o_data  (w_head[d]),
            .o_full  (w_full[d]),
            .o_empty (w_empty[d]),
            .o_count (w_occ[d])
        );
    end

    // Round-robin only matters when both heads need the output slot in the same cycle.
    assign w_slot_free = ~r_cq_valid | cq_ready;
    assign w_contend   = &w_want;
    assign w_win[0]    = w_slot_free & w_want[0] & (~w_want[1] | ~r_rr);
    assign w_win[1]    = w_slot_free & w_want[1] & (~w_want[0] | r_rr);
    assign w_sel       = w_win[1] ? w_head[1] : w_head[0];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_done_q   <= '0;
            r_done_cnt <= '0;
            r_rr       <= 1'b0;
            r_err      <= 1'b0;
            r_cq_valid <= 1'b0;
            r_cq       <= '0;
        end else begin
            r_done_q <= {wr_done, rd_done};
            for (int i = 0; i < 2; i++)
                r_done_cnt[i] <= r_done_cnt[i] + CW'(w_inc[i]) - CW'(w_pop[i]);
            r_err <= r_err | (|w_under);
            if (w_slot_free & w_contend) r_rr <= ~r_rr;
            if (|w_win) begin
                r_cq_valid  <= 1'b1;
                r_cq.opcode <= w_win[1] ? CQ_WR : CQ_RD;
                r_cq.pid    <= w_sel[DW-2 -: PID_BITS];
                r_cq.dest   <= w_sel[DEST_BITS-1:0];
            end else if (cq_ready) begin
                r_cq_valid <= 1'b0;
            end
        end
    end

    assign cq_valid      = r_cq_valid;
    assign cq_opcode     = r_cq.opcode;
    assign cq_pid        = r_cq.pid;
    assign cq_dest       = r_cq.dest;
    assign err_underflow = r_err;

`ifdef DTU_CQ_STATS_EN
    logic [31:0] r_rd_cmpl, r_wr_cmpl;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rd_cmpl <= '0;
            r_wr_cmpl <= '0;
        end else if (r_cq_valid & cq_ready) begin
            if (r_cq.opcode == CQ_WR) r_wr_cmpl <= r_wr_cmpl + 32'd1;
            else r_rd_cmpl <= r_rd_cmpl + 32'd1;
        end
    end

    assign stat_rd_cmpl  = r_rd_cmpl;
    assign stat_wr_cmpl  = r_wr_cmpl;
    assign stat_rd_outst = w_occ[0];
    assign stat_wr_outst = w_occ[1];
`endif
endmodule

// File: tb/tb_dtu_cq_gen.sv
// tb_dtu_cq_gen: scoreboard bench for dtu_cq_gen; a queue-based model predicts CQ entries per
// direction and a negedge monitor checks every handshake, plus directed timing/order checks.
module tb_dtu_cq_gen;
    import dtu_cq_gen_pkg::*;

    typedef struct packed {
        logic                 last;
        logic [PID_BITS-1:0]  pid;
        logic [DEST_BITS-1:0] dest;
    } desc_t;

    logic aclk = 0, areset = 1;
    logic rd_req_valid = 0, rd_req_last = 0, wr_req_valid = 0, wr_req_last = 0;
    logic [PID_BITS-1:0] rd_req_pid = 0, wr_req_pid = 0;
    logic [DEST_BITS-1:0] rd_req_dest = 0, wr_req_dest = 0;
    logic rd_done = 0, wr_done = 0, cq_ready = 1;
    logic rd_req_ready, wr_req_ready, cq_valid, cq_opcode, err_underflow;
    logic [PID_BITS-1:0] cq_pid;
    logic [DEST_BITS-1:0] cq_dest;
`ifdef DTU_CQ_STATS_EN
    logic [31:0] stat_rd_cmpl, stat_wr_cmpl;
    logic [4:0] stat_rd_outst, stat_wr_outst;
`endif

    dtu_cq_gen dut (
        .aclk(aclk), .areset(areset),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_pid(rd_req_pid),
        .rd_req_dest(rd_req_dest), .rd_req_last(rd_req_last),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_pid(wr_req_pid),
        .wr_req_dest(wr_req_dest), .wr_req_last(wr_req_last),
        .rd_done(rd_done), .wr_done(wr_done),
        .cq_valid(cq_valid), .cq_ready(cq_ready), .cq_opcode(cq_opcode),
        .cq_pid(cq_pid), .cq_dest(cq_dest), .err_underflow(err_underflow)
`ifdef DTU_CQ_STATS_EN
        , .stat_rd_cmpl(stat_rd_cmpl), .stat_wr_cmpl(stat_wr_cmpl),
        .stat_rd_outst(stat_rd_outst), .stat_wr_outst(stat_wr_outst)
`endif
    );

    always #5 aclk = ~aclk;

    desc_t md_q[2][$];
    desc_t exp_q[2][$];
    logic  ord_q[$];
    int    n_cmp = 0, n_bad = 0, n_hs = 0;
    int    m_cmpl[2] = '{0, 0};
    bit    m_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Model: each done retires the oldest un-done descriptor; only last=1 ones produce entries.
    task automatic model_done(input int d);
        desc_t x;
        if (md_q[d].size() == 0) m_err = 1;
        else begin
            x = md_q[d].pop_front();
            if (x.last) begin
                exp_q[d].push_back(x);
                m_cmpl[d]++;
            end
        end
    endtask

    task automatic step(input bit rv, input bit wv, input bit rdn, input bit wdn, input bit rdy,
                        input desc_t ra, input desc_t wa);
        rd_req_valid = rv; {rd_req_last, rd_req_pid, rd_req_dest} = ra;
        wr_req_valid = wv; {wr_req_last, wr_req_pid, wr_req_dest} = wa;
        rd_done = rdn; wr_done = wdn; cq_ready = rdy;
        if (rdn) model_done(0);
        if (wdn) model_done(1);
        @(negedge aclk);
        if (rv && rd_req_ready) md_q[0].push_back(ra);
        if (wv && wr_req_ready) md_q[1].push_back(wa);
        @(posedge aclk); #1;
        rd_req_valid = 0; wr_req_valid = 0; rd_done = 0; wr_done = 0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, rdy, '0, '0);
    endtask

    function automatic desc_t rnd_desc();
        desc_t x;
        x.last = 1'($urandom_range(0, 1));
        x.pid  = PID_BITS'($urandom);
        x.dest = DEST_BITS'($urandom);
        return x;
    endfunction

    // Monitor: every handshake is checked against the per-opcode expectation; stalls must hold.
    bit hold = 0;
    logic [31:0] held;
    always @(negedge aclk) begin
        desc_t e;
        if (areset) hold = 0;
        else begin
            if (hold) begin
                chk("hold_valid", {31'b0, cq_valid}, 1);
                chk("hold_entry", {cq_opcode, cq_pid, cq_dest}, held);
            end
            if (cq_valid && cq_ready) begin
                n_hs++;
                ord_q.push_back(cq_opcode);
                if (exp_q[cq_opcode].size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL cq_unexpected: got op %0d pid %0h dest %0h, none expected",
                             cq_opcode, cq_pid, cq_dest);
                end else begin
                    e = exp_q[cq_opcode].pop_front();
                    chk("cq_entry", {cq_pid, cq_dest}, {e.pid, e.dest});
                end
            end
            hold = cq_valid && !cq_ready;
            held = {cq_opcode, cq_pid, cq_dest};
        end
    end

    initial begin
        desc_t a, b;
        int h0;
        bit rdn, wdn;
        // Reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("reset_rd_ready", {31'b0, rd_req_ready}, 0);
        chk("reset_wr_ready", {31'b0, wr_req_ready}, 0);
        chk("reset_cq_valid", {31'b0, cq_valid}, 0);
        @(posedge aclk); #1;
        areset = 0;
        idle(1, 1);
        chk("post_reset_rd_ready", {31'b0, rd_req_ready}, 1);
        chk("post_reset_wr_ready", {31'b0, wr_req_ready}, 1);
        chk("post_reset_err", {31'b0, err_underflow}, 0);

        // Latency: done sampled at edge N, cq_valid from edge N+2, one cycle
        step(1, 0, 0, 0, 1, {1'b1, 6'd3, 4'd1}, '0);
        idle(1, 1);
        step(0, 0, 1, 0, 1, '0, '0);
        chk("lat_n", {31'b0, cq_valid}, 0);
        idle(1, 1);
        chk("lat_n1", {31'b0, cq_valid}, 0);
        idle(1, 1);
        chk("lat_n2_valid", {31'b0, cq_valid}, 1);
        chk("lat_n2_entry", {cq_opcode, cq_pid, cq_dest}, {1'b0, 6'd3, 4'd1});
        idle(1, 1);
        chk("lat_n3_valid", {31'b0, cq_valid}, 0);

        // last=0 retires silently
        h0 = n_hs;
        step(1, 0, 0, 0, 1, {1'b0, 6'd4, 4'd2}, '0);
        step(1, 0, 0, 0, 1, {1'b1, 6'd5, 4'd3}, '0);
        step(0, 0, 1, 0, 1, '0, '0);
        step(0, 0, 1, 0, 1, '0, '0);
        idle(6, 1);
        chk("silent_count", n_hs - h0, 1);
        chk("silent_drained", exp_q[0].size(), 0);
`ifdef DTU_CQ_STATS_EN
        chk("silent_outst", {27'b0, stat_rd_outst}, 0);
`endif

        // Round-robin: first contention rd wins, second contention wr wins
        for (int r = 0; r < 2; r++) begin
            ord_q.delete();
            step(1, 1, 0, 0, 1, {1'b1, 6'(10 + r), 4'd4}, {1'b1, 6'(20 + r), 4'd5});
            step(0, 0, 1, 1, 1, '0, '0);
            idle(6, 1);
            chk("rr_count", ord_q.size(), 2);
            chk("rr_first", {31'b0, ord_q[0]}, r);
            chk("rr_second", {31'b0, ord_q[1]}, 1 - r);
        end

        // Full FIFO, then backpressure with all 16 done
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 1, {1'b1, 6'(i), 4'(i)}, '0);
        chk("full_ready", {31'b0, rd_req_ready}, 0);
        chk("full_accepted", md_q[0].size(), 16);
        h0 = n_hs;
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, '0, '0);
        idle(10, 0);
        chk("stall_valid", {31'b0, cq_valid}, 1);
        chk("stall_entry", {cq_opcode, cq_pid, cq_dest}, {1'b0, 6'd0, 4'd0});
        idle(30, 1);
        chk("full_drain_count", n_hs - h0, 16);
        chk("full_drained", exp_q[0].size(), 0);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            a = rnd_desc();
            b = rnd_desc();
            rdn = md_q[0].size() > 0 && $urandom_range(0, 2) == 0;
            wdn = md_q[1].size() > 0 && $urandom_range(0, 2) == 0;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdn, wdn,
                 $urandom_range(0, 3) != 0, a, b);
        end
        for (int c = 0; c < 80 && (md_q[0].size() + md_q[1].size()) > 0; c++)
            step(0, 0, md_q[0].size() > 0, md_q[1].size() > 0, 1, '0, '0);
        idle(10, 1);
        chk("rand_rd_drained", exp_q[0].size(), 0);
        chk("rand_wr_drained", exp_q[1].size(), 0);
        chk("rand_no_err", {31'b0, err_underflow}, {31'b0, m_err});
`ifdef DTU_CQ_STATS_EN
        chk("stat_rd_cmpl", stat_rd_cmpl, m_cmpl[0]);
        chk("stat_wr_cmpl", stat_wr_cmpl, m_cmpl[1]);
        chk("stat_wr_outst", {27'b0, stat_wr_outst}, 0);
`endif

        // Underflow is sticky and does not disturb normal flow
        step(0, 0, 1, 0, 1, '0, '0);
        idle(3, 1);
        chk("underflow_set", {31'b0, err_underflow}, 1);
        h0 = n_hs;
        step(1, 0, 0, 0, 1, {1'b1, 6'd7, 4'd2}, '0);
        step(0, 0, 1, 0, 1, '0, '0);
        idle(5, 1);
        chk("underflow_sticky", {31'b0, err_underflow}, 1);
        chk("underflow_then_entry", n_hs - h0, 1);

        // Reset mid-operation flushes everything
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, {1'b1, 6'(40 + i), 4'd6}, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, '0, '0);
        idle(3, 0);
        chk("pre_reset_valid", {31'b0, cq_valid}, 1);
        areset = 1;
        #1;
        chk("flush_valid", {31'b0, cq_valid}, 0);
        chk("flush_err", {31'b0, err_underflow}, 0);
        chk("flush_ready", {31'b0, rd_req_ready}, 0);
`ifdef DTU_CQ_STATS_EN
        chk("flush_stat_cmpl", stat_rd_cmpl | stat_wr_cmpl, 0);
        chk("flush_stat_outst", {27'b0, stat_rd_outst | stat_wr_outst}, 0);
`endif
        for (int d = 0; d < 2; d++) begin
            md_q[d].delete();
            exp_q[d].delete();
        end
        m_err = 0;
        @(posedge aclk); @(posedge aclk); #1;
        areset = 0;
        h0 = n_hs;
        idle(20, 1);
        chk("flush_no_stale", n_hs - h0, 0);
        chk("flush_idle_valid", {31'b0, cq_valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
